// File: rtl/iter_divider_pkg.sv
// Shared constants for the iterative DIV/DIVU unit: state encoding,
// default operand width and the divide-by-zero quotient.
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV0_Q = '1;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so WIDTH+1 bits cover the signed trial result
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU; one quotient bit per cycle,
// quotient to LO (div_q) and remainder to HI (div_r).
//
// state    | meaning
// ---------+----------------------------------------------------------
// DIV_IDLE | ready for a request; div_q/div_r hold the last result
// DIV_CALC | iterating, counter selects the step (0..WIDTH-1)
// DIV_DONE | single-cycle result pulse, then back to IDLE
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic             div_cancel,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  output logic             div_ready,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_r
);

  div_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dvs, raw_a;
  logic             sign_q, sign_r, div0;
  logic [WIDTH-1:0] rem_nxt, uq;
  logic             q_bit;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             accept, last_step, finish;

  assign accept    = (state == DIV_IDLE) && div_valid && !div_cancel;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign finish    = (state == DIV_CALC) && !div_cancel && last_step;

  assign a_abs = (div_signed && div_a[WIDTH-1]) ? -div_a : div_a;
  assign b_abs = (div_signed && div_b[WIDTH-1]) ? -div_b : div_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // dvd doubles as the quotient shift register: dividend bits leave at the top
  assign uq = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = DIV_CALC;
      DIV_CALC: begin
        if (div_cancel)     state_nxt = DIV_IDLE;
        else if (last_step) state_nxt = DIV_DONE;
      end
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      raw_a  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      div_q  <= '0;
      div_r  <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        rem    <= '0;
        dvd    <= a_abs;
        dvs    <= b_abs;
        raw_a  <= div_a;
        sign_q <= div_signed & (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
        sign_r <= div_signed & div_a[WIDTH-1];
        div0   <= (div_b == '0);
      end else if (state == DIV_CALC) begin
        cnt <= cnt + 1'b1;
        rem <= rem_nxt;
        dvd <= uq;
      end
      if (finish) begin
        div_q <= div0 ? WIDTH'(DIV0_Q) : (sign_q ? -uq : uq);
        div_r <= div0 ? raw_a : (sign_r ? -rem_nxt : rem_nxt);
      end
    end
  end

  assign div_ready = (state == DIV_IDLE);
  assign div_busy  = (state != DIV_IDLE);
  // a flush landing in the DONE cycle must not let the result retire
  assign div_done  = (state == DIV_DONE) && !div_cancel;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: timing, signed/unsigned results,
// divide by zero, overflow, cancel and asynchronous reset.
module tb_iter_divider;

  logic        clk;
  logic        resetn;
  logic        div_valid;
  logic        div_signed;
  logic        div_cancel;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_ready;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  int checks = 0;
  int errors = 0;

  iter_divider dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_signed (div_signed),
    .div_cancel (div_cancel),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_ready  (div_ready),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_q      (div_q),
    .div_r      (div_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the divider idle; returns at negedge of cycle T+34.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q_exp,
                         input logic [31:0] r_exp);
    int          done_at;
    int          done_cnt;
    int          busy_cnt;
    logic        rdy34;
    logic [31:0] q_s;
    logic [31:0] r_s;
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    rdy34    = 1'b0;
    q_s      = '0;
    r_s      = '0;
    div_a      = a;
    div_b      = b;
    div_signed = sgn;
    div_valid  = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (div_busy) busy_cnt++;
      if (div_done) begin
        done_cnt++;
        done_at = n;
        q_s = div_q;
        r_s = div_r;
      end
      if (n == 34) rdy34 = div_ready;
    end
    check({tag, "_done_at"}, 32'(done_at), 32'd33);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd33);
    check({tag, "_ready34"}, 32'(rdy34), 32'd1);
    check({tag, "_q"}, q_s, q_exp);
    check({tag, "_r"}, r_s, r_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          done_cnt;
    int          rises;
    int          second_at;
    logic        prev_busy;

    resetn     = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    div_cancel = 1'b0;
    div_a      = '0;
    div_b      = '0;
    #12;
    check("rst_ready", 32'(div_ready), 32'd1);
    check("rst_busy", 32'(div_busy), 32'd0);
    check("rst_done", 32'(div_done), 32'd0);
    check("rst_q", div_q, 32'd0);
    check("rst_r", div_r, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_div("divu_7_2",      1'b0, 32'd7,        32'd2,        32'h00000003, 32'h00000001);
    run_div("div_m7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("div_7_m2",      1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    run_div("div_ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_div("divu_ovf_ops",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_div("divu_5_0",      1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005);
    run_div("div_m5_0",      1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB);
    run_div("divu_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000);
    run_div("divu_100_3",    1'b0, 32'd100,      32'd3,        32'h00000021, 32'h00000001);

    // Cancel in CALC: previous result 3/1 must survive
    run_div("pre_cancel",    1'b0, 32'd7,        32'd2,        32'h00000003, 32'h00000001);
    done_cnt   = 0;
    div_a      = 32'd100;
    div_b      = 32'd3;
    div_signed = 1'b0;
    div_valid  = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (div_done) done_cnt++;
      if (n == 10) begin
        check("cancel_busy_t10", 32'(div_busy), 32'd1);
        div_cancel = 1'b1;
      end
      if (n == 11) begin
        check("cancel_ready_t11", 32'(div_ready), 32'd1);
        div_cancel = 1'b0;
      end
    end
    check("cancel_no_done", 32'(done_cnt), 32'd0);
    check("cancel_q_kept", div_q, 32'h00000003);
    check("cancel_r_kept", div_r, 32'h00000001);

    // Cancel in the DONE cycle itself
    done_cnt   = 0;
    div_a      = 32'd100;
    div_b      = 32'd3;
    div_valid  = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (n < 33 && div_done) done_cnt++;
      if (n == 33) begin
        check("dcancel_in_done_busy", 32'(div_busy), 32'd1);
        div_cancel = 1'b1;
        #1;
        if (div_done) done_cnt++;
      end
    end
    check("dcancel_no_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    check("dcancel_ready", 32'(div_ready), 32'd1);
    check("dcancel_done_low", 32'(div_done), 32'd0);
    div_cancel = 1'b0;
    @(negedge clk);

    // div_valid held high: accepts only at T and T+34
    rises      = 0;
    second_at  = -1;
    div_a      = 32'd7;
    div_b      = 32'd2;
    div_signed = 1'b0;
    div_valid  = 1'b1;
    prev_busy  = div_busy;
    @(posedge clk);
    for (int n = 1; n <= 39; n++) begin
      @(negedge clk);
      if (div_busy && !prev_busy) begin
        rises++;
        if (rises == 2) second_at = n;
      end
      prev_busy = div_busy;
    end
    check("held_accepts", 32'(rises), 32'd2);
    check("held_second_busy_cycle", 32'(second_at), 32'd35);
    @(posedge clk);
    #2;
    check("prereset_busy", 32'(div_busy), 32'd1);
    check("prereset_q", div_q, 32'h00000003);
    resetn = 1'b0;
    #1;
    check("areset_busy", 32'(div_busy), 32'd0);
    check("areset_ready", 32'(div_ready), 32'd1);
    check("areset_q", div_q, 32'd0);
    check("areset_r", div_r, 32'd0);
    div_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(div_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
